// File: rtl/bist_pattern_checker.sv
// bist_pattern_checker
// Datapath stage behind the BIST controller. While the controller is in its
// test state, an LFSR generates patterns and a MISR compacts the DUT responses.
// On finish, the signature is compared to GOLDEN. The pass/fail verdict is
// held until the next init.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   init, mode,        controller strobes (init restarts a test, mode applies
//   running, finish    a pattern, finish requests the verdict)
//   dut_resp           DUT response to the current test_pattern
//   test_pattern       current LFSR value (registered)
//   test_en            pattern applied / response captured this cycle (comb)
//   pattern_count      saturating count of applied patterns
//   done, pass, fail   verdict (registered; pass/fail valid when done)
//   signature          live MISR value, present only with BIST_SIGNATURE_OUT_EN
//
// Optional feature macro: BIST_SIGNATURE_OUT_EN
module bist_pattern_checker #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] MISR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN    = 8'h00,
    parameter int unsigned     CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 mode,
    input  logic                 running,
    input  logic                 finish,
    input  logic [WIDTH-1:0]     dut_resp,
    output logic [WIDTH-1:0]     test_pattern,
    output logic                 test_en,
    output logic [CNT_WIDTH-1:0] pattern_count,
    output logic                 done,
    output logic                 pass,
    output logic                 fail
`ifdef BIST_SIGNATURE_OUT_EN
   ,output logic [WIDTH-1:0]     signature
`endif
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [WIDTH-1:0] SEED = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]     misr_q, misr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;

    logic                 load_c;
    logic                 step_c;
    logic                 eval_c;

    // running never affects the datapath; it is only observed here
    logic                 unused_running;
    assign unused_running = running;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: init wins in every state
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (finish) state_d = S_EVAL;
                S_EVAL:  state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs / datapath controls
    always_comb begin
        test_en = mode && (state_q == S_RUN);
        load_c  = init;
        step_c  = test_en && !init;
        eval_c  = (state_q == S_EVAL) && !init;
    end

    // Datapath next values
    always_comb begin
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        pass_d = pass_q;
        fail_d = fail_q;
        if (load_c) begin
            lfsr_d = SEED;
            misr_d = '0;
            cnt_d  = '0;
            done_d = 1'b0;
            pass_d = 1'b0;
            fail_d = 1'b0;
        end else begin
            if (step_c) begin
                lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
                misr_d = {misr_q[WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ dut_resp;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            if (eval_c) begin
                done_d = 1'b1;
                pass_d = (misr_q == GOLDEN);
                fail_d = (misr_q != GOLDEN);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
            misr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            misr_q <= misr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    assign test_pattern  = lfsr_q;
    assign pattern_count = cnt_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
`ifdef BIST_SIGNATURE_OUT_EN
    assign signature     = misr_q;
`endif

endmodule
